// File: rtl/mux_n_a_1_rr_if.sv
// Stream bundle for mux_n_a_1_rr: N producer channels in, one registered channel out.
// Signal names keep the historical i_/o_ prefixes as seen from the mux.
interface mux_n_a_1_rr_if #(
    parameter int N = 4,
    parameter int W = 4
);
    localparam int SW = $clog2(N);

    logic [N*W-1:0] i_Datos;
    logic [N-1:0]   i_valid;
    logic [N-1:0]   o_ready;
    logic [SW-1:0]  i_sel;
    logic           i_modo;
    logic [W-1:0]   o_Dato;
    logic           o_valid;
    logic           i_ready;
    logic [SW-1:0]  o_canal;

    // Handshake rule for every channel, in and out: a beat moves on a rising edge
    // where valid && ready; valid must not depend on ready, and data is stable
    // while valid waits for ready.
    modport slave (
        input  i_Datos, i_valid, i_sel, i_modo, i_ready,
        output o_ready, o_Dato, o_valid, o_canal
    );

    modport master (
        output i_Datos, i_valid, i_sel, i_modo, i_ready,
        input  o_ready, o_Dato, o_valid, o_canal
    );
endinterface

// File: rtl/mux_n_a_1_rr.sv
// N-channel registered stream multiplexer, manual or round-robin channel choice.
// Optional handshake counter on o_cuenta when MUX_CUENTA_EN is defined.
module mux_n_a_1_rr #(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    mux_n_a_1_rr_if.slave       bus,
`ifdef MUX_CUENTA_EN
    output logic [15:0]         o_cuenta,
`endif
    output logic                estado
);
    localparam int SW = $clog2(N);

    typedef enum logic {VACIO = 1'b0, LLENO = 1'b1} state_t;

    state_t          state;
    logic [SW-1:0]   ptr;
    logic [W-1:0]    dato_q;
    logic [SW-1:0]   canal_q;
    logic            valid_q;

    logic            accept;
    logic [SW-1:0]   sel_ch;
    logic [SW-1:0]   rr_ch;
    logic            rr_found;
    logic [SW-1:0]   ch;
    logic            grant;

    assign accept = (state == VACIO) || (bus.i_ready && valid_q);
    assign sel_ch = (int'(bus.i_sel) >= N) ? SW'(N - 1) : bus.i_sel;

    // Scan starts one past the last granted channel so every valid channel is served in turn.
    always_comb begin
        rr_found = 1'b0;
        rr_ch    = '0;
        for (int off = 1; off <= N; off++) begin
            if (!rr_found && bus.i_valid[(int'(ptr) + off) % N]) begin
                rr_found = 1'b1;
                rr_ch    = SW'((int'(ptr) + off) % N);
            end
        end
    end

    always_comb begin
        ch    = bus.i_modo ? rr_ch : sel_ch;
        grant = 1'b0;
        if (!i_rst && accept)
            grant = bus.i_modo ? rr_found : bus.i_valid[sel_ch];
    end

    assign bus.o_ready = grant ? (N'(1) << ch) : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= VACIO;
            valid_q <= 1'b0;
            dato_q  <= '0;
            canal_q <= '0;
            ptr     <= SW'(N - 1);
        end else if (grant) begin
            state   <= LLENO;
            valid_q <= 1'b1;
            dato_q  <= bus.i_Datos[int'(ch)*W +: W];
            canal_q <= ch;
            if (bus.i_modo)
                ptr <= ch;
        end else if (accept && valid_q) begin
            // Consumer took the last beat and nothing new arrived: empty, keep data/channel.
            state   <= VACIO;
            valid_q <= 1'b0;
        end
    end

    assign bus.o_Dato  = dato_q;
    assign bus.o_canal = canal_q;
    assign bus.o_valid = valid_q;
    assign estado      = state;

`ifdef MUX_CUENTA_EN
    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_cuenta <= '0;
        else if (valid_q && bus.i_ready && o_cuenta != 16'hFFFF)
            o_cuenta <= o_cuenta + 16'd1;
    end
`endif
endmodule

// File: tb/tb_mux_n_a_1_rr.sv
// Directed bench for mux_n_a_1_rr: vector table plus reset, N=3 and counter sequences.
module tb_mux_n_a_1_rr;
    localparam int N = 4;
    localparam int W = 4;

    logic clk;
    logic rst;
    logic estado;
    logic estado3;
`ifdef MUX_CUENTA_EN
    logic [15:0] cuenta;
    logic [15:0] cuenta3;
`endif

    mux_n_a_1_rr_if #(.N(N), .W(W)) bus ();
    mux_n_a_1_rr_if #(.N(3), .W(W)) bus3 ();

    mux_n_a_1_rr #(.N(N), .W(W)) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus),
`ifdef MUX_CUENTA_EN
        .o_cuenta(cuenta),
`endif
        .estado(estado)
    );

    mux_n_a_1_rr #(.N(3), .W(W)) dut3 (
        .i_clk(clk), .i_rst(rst), .bus(bus3),
`ifdef MUX_CUENTA_EN
        .o_cuenta(cuenta3),
`endif
        .estado(estado3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        modo;
        logic [1:0]  sel;
        logic [3:0]  valid;
        logic        rdy;
        logic [15:0] datos;
        logic [3:0]  e_ready;
        logic        e_valid;
        logic [3:0]  e_dato;
        logic [1:0]  e_canal;
    } vec_t;

    localparam int NV = 24;
    vec_t vec [NV];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            modo sel valid  rdy datos     ready  vld dato canal
        vec[0]  = '{1'b0, 2'd2, 4'b0100, 1'b1, 16'h4A21, 4'b0100, 1'b1, 4'hA, 2'd2};
        vec[1]  = '{1'b0, 2'd2, 4'b0000, 1'b1, 16'h4A21, 4'b0000, 1'b0, 4'hA, 2'd2};
        vec[2]  = '{1'b0, 2'd1, 4'b0100, 1'b1, 16'h4A21, 4'b0000, 1'b0, 4'hA, 2'd2};
        vec[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 16'h4321, 4'b0001, 1'b1, 4'h1, 2'd0};
        vec[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 16'h4321, 4'b0010, 1'b1, 4'h2, 2'd1};
        vec[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 16'h4321, 4'b0100, 1'b1, 4'h3, 2'd2};
        vec[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 16'h4321, 4'b1000, 1'b1, 4'h4, 2'd3};
        vec[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 16'h4321, 4'b0001, 1'b1, 4'h1, 2'd0};
        vec[8]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 16'h4321, 4'b0010, 1'b1, 4'h2, 2'd1};
        vec[9]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 16'h4321, 4'b0100, 1'b1, 4'h3, 2'd2};
        vec[10] = '{1'b1, 2'd0, 4'b1111, 1'b1, 16'h4321, 4'b1000, 1'b1, 4'h4, 2'd3};
        vec[11] = '{1'b0, 2'd1, 4'b0010, 1'b1, 16'h4351, 4'b0010, 1'b1, 4'h5, 2'd1};
        vec[12] = '{1'b1, 2'd0, 4'b1111, 1'b0, 16'h4351, 4'b0000, 1'b1, 4'h5, 2'd1};
        vec[13] = '{1'b1, 2'd0, 4'b1111, 1'b0, 16'h4351, 4'b0000, 1'b1, 4'h5, 2'd1};
        vec[14] = '{1'b1, 2'd0, 4'b1111, 1'b0, 16'h4351, 4'b0000, 1'b1, 4'h5, 2'd1};
        vec[15] = '{1'b1, 2'd0, 4'b1111, 1'b1, 16'h4351, 4'b0001, 1'b1, 4'h1, 2'd0};
        vec[16] = '{1'b1, 2'd0, 4'b0100, 1'b1, 16'h4321, 4'b0100, 1'b1, 4'h3, 2'd2};
        vec[17] = '{1'b1, 2'd0, 4'b0011, 1'b1, 16'h4321, 4'b0001, 1'b1, 4'h1, 2'd0};
        vec[18] = '{1'b1, 2'd0, 4'b0011, 1'b1, 16'h4321, 4'b0010, 1'b1, 4'h2, 2'd1};
        vec[19] = '{1'b0, 2'd3, 4'b1000, 1'b1, 16'h4321, 4'b1000, 1'b1, 4'h4, 2'd3};
        vec[20] = '{1'b1, 2'd0, 4'b0000, 1'b1, 16'h4321, 4'b0000, 1'b0, 4'h4, 2'd3};
        vec[21] = '{1'b1, 2'd0, 4'b0000, 1'b0, 16'h4321, 4'b0000, 1'b0, 4'h4, 2'd3};
        vec[22] = '{1'b1, 2'd0, 4'b1001, 1'b0, 16'h4321, 4'b1000, 1'b1, 4'h4, 2'd3};
        vec[23] = '{1'b1, 2'd0, 4'b1001, 1'b0, 16'h4321, 4'b0000, 1'b1, 4'h4, 2'd3};

        bus.i_Datos = 16'h4321; bus.i_valid = 4'b1111; bus.i_sel = 2'd0;
        bus.i_modo = 1'b1; bus.i_ready = 1'b1;
        bus3.i_Datos = 12'hCBA; bus3.i_valid = 3'b000; bus3.i_sel = 2'd0;
        bus3.i_modo = 1'b0; bus3.i_ready = 1'b1;

        // Reset held two cycles with every channel valid.
        rst = 1'b1;
        tick();
        check("rst ready c1", 32'(bus.o_ready), 32'h0);
        tick();
        check("rst ready c2", 32'(bus.o_ready), 32'h0);
        check("rst valid", 32'(bus.o_valid), 32'h0);
        check("rst dato", 32'(bus.o_Dato), 32'h0);
        check("rst canal", 32'(bus.o_canal), 32'h0);
        check("rst estado", 32'(estado), 32'h0);
        bus.i_valid = 4'b0000;
        rst = 1'b0;
        tick();
        check("idle valid", 32'(bus.o_valid), 32'h0);

        for (int i = 0; i < NV; i++) begin
            bus.i_modo  = vec[i].modo;
            bus.i_sel   = vec[i].sel;
            bus.i_valid = vec[i].valid;
            bus.i_ready = vec[i].rdy;
            bus.i_Datos = vec[i].datos;
            #1;
            check($sformatf("v%0d ready", i), 32'(bus.o_ready), 32'(vec[i].e_ready));
            @(posedge clk);
            #1;
            check($sformatf("v%0d valid", i), 32'(bus.o_valid), 32'(vec[i].e_valid));
            check($sformatf("v%0d dato", i), 32'(bus.o_Dato), 32'(vec[i].e_dato));
            check($sformatf("v%0d canal", i), 32'(bus.o_canal), 32'(vec[i].e_canal));
        end

        // Reset while a beat is held: discarded, and channel 0 has priority again.
        bus.i_valid = 4'b1111; bus.i_modo = 1'b1; bus.i_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst ready", 32'(bus.o_ready), 32'h0);
        tick();
        check("midrst valid", 32'(bus.o_valid), 32'h0);
        rst = 1'b0;
        bus.i_ready = 1'b1;
        #1;
        check("midrst rr ready", 32'(bus.o_ready), 32'b0001);
        tick();
        check("midrst rr canal", 32'(bus.o_canal), 32'h0);
        check("midrst rr dato", 32'(bus.o_Dato), 32'h1);
        bus.i_valid = 4'b0000;
        tick();

        // N=3: an out-of-range select of 3 falls back to channel 2.
        bus3.i_sel = 2'd3; bus3.i_valid = 3'b011;
        #1;
        check("n3 sel3 nogrant", 32'(bus3.o_ready), 32'h0);
        bus3.i_valid = 3'b100;
        #1;
        check("n3 sel3 ready", 32'(bus3.o_ready), 32'b100);
        tick();
        check("n3 valid", 32'(bus3.o_valid), 32'h1);
        check("n3 dato", 32'(bus3.o_Dato), 32'hC);
        check("n3 canal", 32'(bus3.o_canal), 32'd2);
        bus3.i_valid = 3'b000;
        tick();

`ifdef MUX_CUENTA_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("cnt reset", 32'(cuenta), 32'h0);
        bus.i_modo = 1'b1; bus.i_valid = 4'b1111; bus.i_ready = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) tick();
        bus.i_ready = 1'b0;
        check("cnt five", 32'(cuenta), 32'd5);
        tick();
        check("cnt hold", 32'(cuenta), 32'd5);
        bus.i_ready = 1'b1;
        for (int i = 0; i < 65535; i++) tick();
        check("cnt sat", 32'(cuenta), 32'hFFFF);
        tick();
        check("cnt sat hold", 32'(cuenta), 32'hFFFF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("cnt clear", 32'(cuenta), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
